coin_payer: RTL and testbench
=============================

Name: coin_payer

Overview:
Buyer-side counterpart of the newspaper vending machine. It holds a wallet of 5- and 10-unit coins and, on a buy request, drives the machine's coin input one coin per cycle until the price is covered. It then waits for the machine's newspaper pulse and reports done or fail. It sits on the same coin/newspaper interface as the vending machine, replacing the random coin stimulus in system-level benches.

Parameters:
PRICE_UNITS, 3, newspaper price in 5-unit steps (3 = 15)
WALLET_W, 4, width of each wallet coin counter
TIMEOUT, 4, cycles to wait for newspaper after the final coin

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous active-high reset
load  input  1  wallet load strobe, honoured only in IDLE
load_n5  input  WALLET_W  5-unit coin count to load
load_n10  input  WALLET_W  10-unit coin count to load
buy  input  1  purchase request, honoured only in IDLE
newspaper  input  1  dispense pulse from the vending machine
coin  output  2  coin bus: 0 none, 1 five-unit, 2 ten-unit; 3 never driven
busy  output  1  high in PAY and WAIT_ACK
done  output  1  one-cycle pulse, purchase acknowledged
fail  output  1  one-cycle pulse, insufficient funds or timeout
n5_left  output  WALLET_W  current 5-unit coin count
n10_left  output  WALLET_W  current 10-unit coin count

Behaviour:
- Reset (async, immediate): coin=0, busy=0, done=0, fail=0, n5_left=0, n10_left=0, paid=0, timer=0, state=IDLE.
- All outputs are registered.
- IDLE:
  - If load=1: wallet counts take the load values at the edge.
  - Load and buy in the same cycle: load wins, buy is ignored.
  - If buy=1 and load=0: compute value = n5 + 2*n10, with a width of WALLET_W+2 so it cannot overflow.
    - value < PRICE_UNITS: fail pulses in the next cycle, coin stays 0, counts are unchanged, state stays IDLE.
    - Otherwise: go to PAY, paid=0.
- PAY: one coin is driven per cycle, with consecutive coins allowed. The coin is chosen at each edge from rem = PRICE_UNITS - paid:
  - rem >= 2 and n10 > 0: drive 2, decrement n10.
  - else if n5 > 0: drive 1, decrement n5.
  - else: drive 2 and decrement n10 (overpay by 1; no change is returned).
  - paid increases by the coin's value. The funds pre-check guarantees a coin is always available.
  - The first coin appears in the cycle after the buy edge.
- When paid >= PRICE_UNITS after the current coin: go to WAIT_ACK, coin returns to 0 on the following edge, and timer=0.
- newspaper sampling:
  - newspaper is sampled from the cycle the final coin is on the bus onward. A same-cycle (Mealy) response is accepted.
  - newspaper=1 earlier in PAY is ignored.
- WAIT_ACK:
  - newspaper=1: done pulses in the next cycle, go to IDLE.
  - Otherwise timer increments. After TIMEOUT cycles without newspaper: fail pulses in the next cycle and the state returns to IDLE. Spent coins are not refunded.
- busy drops in the same cycle that done or fail pulses.
- load and buy are ignored while busy=1.
- Reset mid-operation: the transfer is aborted, the wallet is cleared, and no done or fail pulse is issued.
- Counters never wrap. Decrement at 0 is unreachable by construction; verification asserts this.

Test Plan:
1. Load n5=3, n10=2; buy; machine pulses newspaper 1 cycle after the last coin. Required: coin sequence 2,1 on consecutive cycles, then 0; done pulses once; n5_left=2, n10_left=1.
2. Load n5=0, n10=2; buy. Required: coin 2,2 (overpay); newspaper same cycle as the second coin; done pulses; n10_left=0.
3. Load n5=1, n10=0; buy. Required: fail pulses 1 cycle after buy; coin stays 0 throughout; busy stays 0; counts remain 1/0.
4. Load n5=3, n10=0; buy; newspaper held 0. Required: coin 1,1,1; fail after exactly 4 WAIT_ACK cycles; n5_left=0.
5. Load n5=2, n10=2; buy; assert rst during the second PAY cycle. Required: coin=0 and busy=0 asynchronously; counts 0; no done or fail pulse.
6. load and buy asserted together in IDLE, then load pulsed while busy. Required: only the first load takes effect; no purchase starts; the busy-time load is ignored.

Source files
------------

// File: rtl/coin_payer.sv
// Buyer-side coin driver for the newspaper vending machine.
// Pays from a 5/10-unit wallet one coin per cycle, then waits for the dispense pulse.
module coin_payer #(
    parameter int PRICE_UNITS = 3,
    parameter int WALLET_W    = 4,
    parameter int TIMEOUT     = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [WALLET_W-1:0] load_n5,
    input  logic [WALLET_W-1:0] load_n10,
    input  logic                buy,
    input  logic                newspaper,
    output logic [1:0]          coin,
    output logic                busy,
    output logic                done,
    output logic                fail,
    output logic [WALLET_W-1:0] n5_left,
    output logic [WALLET_W-1:0] n10_left
);

    typedef enum logic [1:0] {IDLE, PAY, WAIT_ACK} state_t;

    // paid can reach PRICE_UNITS+1 after an overpaying 10-unit coin
    localparam int PW = $clog2(PRICE_UNITS + 2) + 1;
    localparam int TW = $clog2(TIMEOUT + 1) + 1;
    localparam int VW = WALLET_W + 2;
    localparam logic [PW-1:0] PRICE_P = PW'(PRICE_UNITS);
    localparam logic [VW-1:0] PRICE_V = VW'(PRICE_UNITS);
    localparam logic [TW-1:0] T_LAST  = TW'(TIMEOUT - 1);

    state_t state, state_d;
    logic [PW-1:0] paid, paid_d, cur_paid, paid_new;
    logic [TW-1:0] timer, timer_d;
    logic [VW-1:0] value;
    logic [1:0] coin_d;
    logic busy_d, done_d, fail_d;
    logic [WALLET_W-1:0] n5_d, n10_d;
    logic funded, start, pay_now, pick10, covered;

    assign value    = {2'b00, n5_left} + {1'b0, n10_left, 1'b0};
    assign funded   = value >= PRICE_V;
    assign start    = (state == IDLE) && buy && !load && funded;
    assign pay_now  = start || (state == PAY);
    assign cur_paid = (state == IDLE) ? '0 : paid;

    // prefer a 10 while at least two units remain, otherwise a 5 if any
    assign pick10   = ((cur_paid + PW'(2) <= PRICE_P) && (n10_left != '0))
                      || (n5_left == '0);
    assign paid_new = cur_paid + (pick10 ? PW'(2) : PW'(1));
    assign covered  = paid_new >= PRICE_P;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            paid     <= '0;
            timer    <= '0;
            coin     <= 2'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
            fail     <= 1'b0;
            n5_left  <= '0;
            n10_left <= '0;
        end else begin
            state    <= state_d;
            paid     <= paid_d;
            timer    <= timer_d;
            coin     <= coin_d;
            busy     <= busy_d;
            done     <= done_d;
            fail     <= fail_d;
            n5_left  <= n5_d;
            n10_left <= n10_d;
        end
    end

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE:     if (start) state_d = covered ? WAIT_ACK : PAY;
            PAY:      if (covered) state_d = WAIT_ACK;
            WAIT_ACK: if (newspaper || timer == T_LAST) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        coin_d  = 2'd0;
        done_d  = 1'b0;
        fail_d  = 1'b0;
        n5_d    = n5_left;
        n10_d   = n10_left;
        paid_d  = paid;
        timer_d = timer;
        busy_d  = state_d != IDLE;
        if (pay_now) begin
            coin_d  = pick10 ? 2'd2 : 2'd1;
            paid_d  = paid_new;
            timer_d = '0;
            if (pick10) n10_d = n10_left - WALLET_W'(1);
            else        n5_d  = n5_left - WALLET_W'(1);
        end else if (state == IDLE) begin
            paid_d = '0;
            if (load) begin
                n5_d  = load_n5;
                n10_d = load_n10;
            end else if (buy) begin
                fail_d = 1'b1;
            end
        end else if (state == WAIT_ACK) begin
            if (newspaper)            done_d  = 1'b1;
            else if (timer == T_LAST) fail_d  = 1'b1;
            else                      timer_d = timer + TW'(1);
        end
    end

endmodule

// File: tb/tb_coin_payer.sv
// Scoreboard bench for coin_payer: stimulus queues expected coin/done/fail
// events with their cycle offset from the buy request; a monitor matches them.
module tb_coin_payer;

    localparam int K5 = 0, K10 = 1, KD = 2, KF = 3, KBAD = 9;

    typedef struct {
        int kind;
        int rel;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic load = 1'b0;
    logic [3:0] load_n5 = '0;
    logic [3:0] load_n10 = '0;
    logic buy = 1'b0;
    logic newspaper = 1'b0;
    logic [1:0] coin;
    logic busy, done, fail;
    logic [3:0] n5_left, n10_left;

    ev_t q[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t0 = 0;
    logic [3:0] p5 = '0;
    logic [3:0] p10 = '0;

    coin_payer #(.PRICE_UNITS(3), .WALLET_W(4), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .load(load), .load_n5(load_n5),
        .load_n10(load_n10), .buy(buy), .newspaper(newspaper),
        .coin(coin), .busy(busy), .done(done), .fail(fail),
        .n5_left(n5_left), .n10_left(n10_left)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic got(input int k);
        ev_t e;
        int r;
        r = cyc - t0;
        checks++;
        if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event kind=%0d rel=%0d required none", k, r);
        end else begin
            e = q.pop_front();
            if (e.kind != k || e.rel != r) begin
                errors++;
                $display("FAIL event got kind=%0d rel=%0d required kind=%0d rel=%0d",
                         k, r, e.kind, e.rel);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (coin == 2'd1) got(K5);
            if (coin == 2'd2) got(K10);
            if (coin == 2'd3) got(KBAD);
            if (done) got(KD);
            if (fail) got(KF);
            if (coin == 2'd1) begin
                checks++;
                if (p5 == 4'd0 || n5_left != p5 - 4'd1) begin
                    errors++;
                    $display("FAIL n5_decrement got %0d required %0d-1", n5_left, p5);
                end
            end
            if (coin == 2'd2) begin
                checks++;
                if (p10 == 4'd0 || n10_left != p10 - 4'd1) begin
                    errors++;
                    $display("FAIL n10_decrement got %0d required %0d-1", n10_left, p10);
                end
            end
        end
        p5  = n5_left;
        p10 = n10_left;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s got %0d required %0d", name, act, req);
        end
    endtask

    task automatic exp_ev(input int k, input int r);
        ev_t e;
        e.kind = k;
        e.rel = r;
        q.push_back(e);
    endtask

    task automatic do_load(input int a, input int b);
        load = 1'b1;
        load_n5 = 4'(a);
        load_n10 = 4'(b);
        step();
        load = 1'b0;
        step();
    endtask

    task automatic run_buy(input int np_rel, input int cycles);
        t0 = cyc;
        buy = 1'b1;
        for (int r = 1; r <= cycles; r++) begin
            step();
            buy = 1'b0;
            newspaper = (r == np_rel);
        end
        newspaper = 1'b0;
    endtask

    initial begin
        repeat (2) step();
        chk("rst_coin", int'(coin), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_fail", int'(fail), 0);
        chk("rst_n5", int'(n5_left), 0);
        chk("rst_n10", int'(n10_left), 0);
        rst = 1'b0;
        step();

        // 1: 10 then 5, newspaper one cycle after the last coin
        do_load(3, 2);
        chk("t1_load_n5", int'(n5_left), 3);
        chk("t1_load_n10", int'(n10_left), 2);
        exp_ev(K10, 1); exp_ev(K5, 2); exp_ev(KD, 4);
        run_buy(3, 6);
        chk("t1_n5", int'(n5_left), 2);
        chk("t1_n10", int'(n10_left), 1);
        chk("t1_busy", int'(busy), 0);

        // 2: overpay with two 10s, Mealy newspaper
        do_load(0, 2);
        exp_ev(K10, 1); exp_ev(K10, 2); exp_ev(KD, 3);
        run_buy(2, 5);
        chk("t2_n10", int'(n10_left), 0);
        chk("t2_n5", int'(n5_left), 0);

        // 3: insufficient funds
        do_load(1, 0);
        exp_ev(KF, 1);
        t0 = cyc;
        buy = 1'b1;
        step();
        buy = 1'b0;
        chk("t3_busy", int'(busy), 0);
        repeat (3) step();
        chk("t3_n5", int'(n5_left), 1);
        chk("t3_n10", int'(n10_left), 0);

        // 4: three 5s, no newspaper, timeout
        do_load(3, 0);
        exp_ev(K5, 1); exp_ev(K5, 2); exp_ev(K5, 3); exp_ev(KF, 7);
        run_buy(-1, 9);
        chk("t4_n5", int'(n5_left), 0);
        chk("t4_busy", int'(busy), 0);

        // 5: reset during the second coin
        do_load(2, 2);
        exp_ev(K10, 1);
        t0 = cyc;
        buy = 1'b1;
        step();
        buy = 1'b0;
        step();
        rst = 1'b1;
        #1;
        chk("t5_coin", int'(coin), 0);
        chk("t5_busy", int'(busy), 0);
        chk("t5_n5", int'(n5_left), 0);
        chk("t5_n10", int'(n10_left), 0);
        repeat (2) step();
        rst = 1'b0;
        repeat (4) step();

        // 6: load beats buy; load while busy is ignored
        load = 1'b1;
        buy = 1'b1;
        load_n5 = 4'd1;
        load_n10 = 4'd1;
        step();
        load = 1'b0;
        buy = 1'b0;
        repeat (3) step();
        chk("t6_n5", int'(n5_left), 1);
        chk("t6_n10", int'(n10_left), 1);
        chk("t6_idle", int'(busy), 0);
        exp_ev(K10, 1); exp_ev(K5, 2); exp_ev(KD, 3);
        t0 = cyc;
        buy = 1'b1;
        step();
        buy = 1'b0;
        load = 1'b1;
        load_n5 = 4'd7;
        load_n10 = 4'd7;
        chk("t6_busy", int'(busy), 1);
        step();
        load = 1'b0;
        newspaper = 1'b1;
        step();
        newspaper = 1'b0;
        repeat (2) step();
        chk("t6_end_n5", int'(n5_left), 0);
        chk("t6_end_n10", int'(n10_left), 0);

        chk("queue_empty", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
